// File: rtl/stat_pkg.sv
// Shared definitions for the status flag unit: flag bit positions and condition codes.
package stat_pkg;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic [3:0] {
    EQ = 4'd0,
    NE = 4'd1,
    CS = 4'd2,
    CC = 4'd3,
    MI = 4'd4,
    PL = 4'd5,
    VS = 4'd6,
    VC = 4'd7,
    HI = 4'd8,
    LS = 4'd9,
    GE = 4'd10,
    LT = 4'd11,
    GT = 4'd12,
    LE = 4'd13,
    AL = 4'd14,
    NV = 4'd15
  } cond_e;

endpackage

// File: rtl/stat_cond_eval.sv
// Combinational condition-code evaluator over {C,V,N,Z}; shared with the branch unit.
module stat_cond_eval
  import stat_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       cond_true
);

  logic c, v, n, z;

  always_comb begin
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    cond_true = 1'b0;
    case (cond_e'(cond))
      EQ: cond_true = z;
      NE: cond_true = !z;
      CS: cond_true = c;
      CC: cond_true = !c;
      MI: cond_true = n;
      PL: cond_true = !n;
      VS: cond_true = v;
      VC: cond_true = !v;
      HI: cond_true = c & !z;
      LS: cond_true = !c | z;
      GE: cond_true = (n == v);
      LT: cond_true = (n != v);
      GT: cond_true = !z & (n == v);
      LE: cond_true = z | (n != v);
      AL: cond_true = 1'b1;
      NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_flag_unit.sv
// Clocked status register with masked load, direct write, LIFO save/restore and cond evaluation.
// Optional sticky saturation flag q_flag is built when STATUS_STICKY_Q_EN is defined.
module status_flag_unit #(
  parameter int unsigned NFLAGS = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [NFLAGS-1:0] load_mask,
  input  logic [NFLAGS-1:0] alu_flags,
  input  logic              wr_en,
  input  logic [NFLAGS-1:0] wr_data,
  input  logic              push,
  input  logic              pop,
  input  logic [3:0]        cond,
  output logic [NFLAGS-1:0] status,
  output logic              cond_true,
  output logic [PTR_W-1:0]  depth,
  output logic              full,
  output logic              empty,
  output logic              err,
  output logic              q_flag
);
  import stat_pkg::*;

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NFLAGS-1:0] status_q, status_d;
  logic [PTR_W-1:0]  depth_q, depth_d;
  logic              err_q, err_d;
  logic [NFLAGS-1:0] stack_q [DEPTH];
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              push_ok, pop_ok;

  assign full  = (depth_q == PTR_W'(DEPTH));
  assign empty = (depth_q == '0);

  // Simultaneous push and pop cancel each other and count as misuse.
  assign push_ok = push & !pop & !full;
  assign pop_ok  = pop & !push & !empty;
  assign wr_idx  = IDX_W'(depth_q);
  assign rd_idx  = IDX_W'(depth_q - PTR_W'(1));

  always_comb begin
    status_d = status_q;
    depth_d  = depth_q;
    err_d    = err_q | (push & pop) | (push & full) | (pop & empty);
    if (pop_ok) begin
      status_d = stack_q[rd_idx];
      depth_d  = depth_q - PTR_W'(1);
    end else begin
      if (wr_en) begin
        status_d = wr_data;
      end else if (load) begin
        status_d = (status_q & ~load_mask) | (alu_flags & load_mask);
      end
      if (push_ok) begin
        depth_d = depth_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
      depth_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      depth_q  <= depth_d;
      err_q    <= err_d;
    end
  end

  // Stack contents are not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      stack_q[wr_idx] <= status_q;
    end
  end

`ifdef STATUS_STICKY_Q_EN
  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (wr_en && !wr_data[FLAG_V]) begin
      q_d = 1'b0;
    end
    if (load && load_mask[FLAG_V] && alu_flags[FLAG_V]) begin
      q_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_flag = q_q;
`else
  assign q_flag = 1'b0;
`endif

  stat_cond_eval u_cond_eval (
    .flags     (status_q[3:0]),
    .cond      (cond),
    .cond_true (cond_true)
  );

  assign status = status_q;
  assign depth  = depth_q;
  assign err    = err_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// Self-checking bench for status_flag_unit: directed scenarios plus randomized traffic vs. a queue model.
module tb_status_flag_unit;

  localparam int NF = 4;
  localparam int DP = 4;
  localparam int PW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          rst, load, wr_en, push, pop;
  logic [NF-1:0] load_mask, alu_flags, wr_data;
  logic [3:0]    cond;
  logic [NF-1:0] status;
  logic          cond_true, full, empty, err, q_flag;
  logic [PW-1:0] depth;

  always #5 clk = ~clk;

  status_flag_unit #(.NFLAGS(NF), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_mask (load_mask),
    .alu_flags (alu_flags),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .push      (push),
    .pop       (pop),
    .cond      (cond),
    .status    (status),
    .cond_true (cond_true),
    .depth     (depth),
    .full      (full),
    .empty     (empty),
    .err       (err),
    .q_flag    (q_flag)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [NF-1:0] m_st;
  logic [NF-1:0] m_stack[$];
  bit            m_err;
  bit            m_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_cond(input logic [3:0] s, input logic [3:0] c);
    bit cf, vf, nf, zf;
    cf = s[3]; vf = s[2]; nf = s[1]; zf = s[0];
    case (c)
      4'd0:  return zf;
      4'd1:  return !zf;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return nf;
      4'd5:  return !nf;
      4'd6:  return vf;
      4'd7:  return !vf;
      4'd8:  return cf && !zf;
      4'd9:  return !cf || zf;
      4'd10: return nf == vf;
      4'd11: return nf != vf;
      4'd12: return !zf && (nf == vf);
      4'd13: return zf || (nf != vf);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge();
    logic [NF-1:0] old_st;
    bit            restored;
    logic [NF-1:0] rest_val;
    if (rst) begin
      m_st = '0;
      m_stack.delete();
      m_err = 0;
      m_q = 0;
      return;
    end
    old_st = m_st;
    restored = 0;
    rest_val = '0;
    if ((push && pop) || (push && m_stack.size() == DP) || (pop && m_stack.size() == 0))
      m_err = 1;
    if (!(push && pop)) begin
      if (push && m_stack.size() < DP) m_stack.push_back(old_st);
      else if (pop && m_stack.size() > 0) begin
        rest_val = m_stack.pop_back();
        restored = 1;
      end
    end
    if (restored) m_st = rest_val;
    else if (wr_en) m_st = wr_data;
    else if (load) m_st = (old_st & ~load_mask) | (alu_flags & load_mask);
`ifdef STATUS_STICKY_Q_EN
    if (wr_en && !wr_data[2]) m_q = 0;
    if (load && load_mask[2] && alu_flags[2]) m_q = 1;
`endif
  endtask

  task automatic check_outputs();
    check_eq("status", status, m_st);
    check_eq("depth", depth, m_stack.size());
    check_eq("full", full, m_stack.size() == DP);
    check_eq("empty", empty, m_stack.size() == 0);
    check_eq("err", err, m_err);
    check_eq("q_flag", q_flag, m_q);
  endtask

  task automatic cyc(input bit r, input bit ld, input logic [3:0] m, input logic [3:0] a,
                     input bit we, input logic [3:0] wd, input bit pu, input bit po,
                     input logic [3:0] c);
    @(negedge clk);
    rst = r; load = ld; load_mask = m; alu_flags = a;
    wr_en = we; wr_data = wd; push = pu; pop = po; cond = c;
    #1;
    check_eq("cond_true", cond_true, ref_cond(m_st, c));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    cyc(0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 4'hE);
  endtask

  task automatic do_reset();
    cyc(1, 0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 4'hE);
  endtask

  task automatic wr(input logic [3:0] v);
    cyc(0, 0, 4'h0, 4'h0, 1, v, 0, 0, 4'hE);
  endtask

  logic [3:0] sweep_vals[6];

  initial begin
    rst = 1; load = 0; load_mask = '0; alu_flags = '0; wr_en = 0; wr_data = '0;
    push = 0; pop = 0; cond = '0;
    m_st = '0; m_err = 0; m_q = 0;

    do_reset();
    do_reset();
    check_eq("rst_status", status, 4'h0);
    check_eq("rst_empty", empty, 1'b1);

    // Masked load
    cyc(0, 1, 4'b0101, 4'b1111, 0, 4'h0, 0, 0, 4'h0);
    check_eq("mask_load", status, 4'b0101);
    cyc(0, 1, 4'b1010, 4'b0000, 0, 4'h0, 0, 0, 4'h0);
    check_eq("mask_hold", status, 4'b0101);

    // wr_en beats load
    wr(4'b0001);
    cyc(0, 1, 4'b1111, 4'b1000, 1, 4'b0110, 0, 0, 4'h0);
    check_eq("wr_over_load", status, 4'b0110);

    // Fill, overflow, drain
    for (int i = 1; i <= 4; i++) begin
      wr(4'(i));
      cyc(0, 0, 4'h0, 4'h0, 0, 4'h0, 1, 0, 4'h0);
    end
    check_eq("fill_full", full, 1'b1);
    check_eq("fill_depth", depth, 3'd4);
    cyc(0, 0, 4'h0, 4'h0, 0, 4'h0, 1, 0, 4'h0);
    check_eq("ovf_err", err, 1'b1);
    check_eq("ovf_depth", depth, 3'd4);
    for (int i = 4; i >= 1; i--) begin
      cyc(0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 1, 4'h0);
      check_eq("pop_order", status, 4'(i));
    end
    check_eq("drain_empty", empty, 1'b1);

    // Push with load, pop discards load
    do_reset();
    wr(4'h9);
    cyc(0, 1, 4'hF, 4'h6, 0, 4'h0, 1, 0, 4'h0);
    check_eq("push_load", status, 4'h6);
    cyc(0, 1, 4'hF, 4'h0, 0, 4'h0, 0, 1, 4'h0);
    check_eq("pop_restore", status, 4'h9);

    // Misuse
    do_reset();
    wr(4'h3);
    cyc(0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 1, 4'h0);
    check_eq("pop_empty_err", err, 1'b1);
    check_eq("pop_empty_st", status, 4'h3);
    do_reset();
    cyc(0, 0, 4'h0, 4'h0, 0, 4'h0, 1, 0, 4'h0);
    cyc(0, 0, 4'h0, 4'h0, 0, 4'h0, 1, 0, 4'h0);
    cyc(0, 0, 4'h0, 4'h0, 0, 4'h0, 1, 1, 4'h0);
    check_eq("pushpop_err", err, 1'b1);
    check_eq("pushpop_depth", depth, 3'd2);
    do_reset();
    check_eq("rst_clears_err", err, 1'b0);

    // Condition sweep
    sweep_vals = '{4'h0, 4'h4, 4'h8, 4'h2, 4'hA, 4'h1};
    foreach (sweep_vals[k]) begin
      wr(sweep_vals[k]);
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        wr_en = 0;
        cond = 4'(c);
        #1;
        check_eq("cond_sweep", cond_true, ref_cond(sweep_vals[k], 4'(c)));
      end
    end
    wr(4'b0010);
    @(negedge clk);
    wr_en = 0;
    cond = 4'd10;
    #1 check_eq("ge_nv_differ", cond_true, 1'b0);
    cond = 4'd13;
    #1 check_eq("le_nv_differ", cond_true, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1), 4'($urandom),
          4'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 4'($urandom));
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
